hazard_control: RTL
===================

# hazard_control

Parametrised pipeline hazard and flow-control unit for the uDLX core, sitting in the decode stage between IF/ID, ID/EX and EX/MEM. It detects load-use hazards against one or two in-flight loads, holds multi-cycle load stalls with a counter, sequences multi-cycle branch flushes, and freezes the whole pipeline while data memory is not ready. Its outputs drive PC enable, IF/ID hold and the ID/EX and IF/ID bubble muxes.

## Interface
- ADDR_W, 5: register address width.
- LOAD_LATENCY, 1: load-use stall depth, legal 1..3. A value of 2 or more enables the EX/MEM compare.
- FLUSH_CYCLES, 1: number of cycles `decode_flush` stays asserted after a taken branch, legal 1..3.
- R0_HARDWIRED, 1: when 1, a destination or source of register 0 never causes a hazard.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_ex_mem_data_rd_en  in  1  the instruction in EX is a load.
- id_ex_reg_wr_addr  in  ADDR_W  destination of the EX instruction.
- ex_mem_mem_data_rd_en  in  1  the instruction in MEM is a load.
- ex_mem_reg_wr_addr  in  ADDR_W  destination of the MEM instruction.
- if_id_rd_reg_a_en, if_id_rd_reg_b_en  in  1  the decode instruction reads source a or source b.
- if_id_rd_reg_a_addr, if_id_rd_reg_b_addr  in  ADDR_W  source addresses.
- select_new_pc  in  1  taken branch or jump resolved this cycle.
- dmem_busy  in  1  data memory cannot complete its access this cycle.
- inst_rd_en  out  1  PC and fetch enable.
- stall  out  1  hold IF/ID.
- general_flush  out  1  flush IF/ID and ID/EX.
- decode_flush  out  1  insert a bubble into ID/EX.
- freeze  out  1  hold every pipeline register.
- stall_count, flush_count  out  CNT_W  present only with the statistics macro (see Configuration).

## Operation
- Hazard terms:
  - hz_ex = id_ex_mem_data_rd_en and (a match or b match) against id_ex_reg_wr_addr.
  - hz_mem = the same compare against ex_mem_reg_wr_addr, only when LOAD_LATENCY ≥ 2.
  - With R0_HARDWIRED, any match on address 0 is masked.
- FSM states: RUN, LOAD_STALL, FLUSH. A separate down-counter `cnt` serves both stall and flush states.
- Priority within a cycle is dmem_busy > select_new_pc > hazard.
- dmem_busy = 1, in any state:
  - Outputs: freeze=1, stall=1, inst_rd_en=0, general_flush=0, decode_flush=0.
  - State and `cnt` are held.
  - select_new_pc and the hazard terms are ignored; the producing stage is frozen and presents them again.
- RUN:
  - select_new_pc: general_flush=1, decode_flush=1, inst_rd_en=1. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1.
  - Else hz_ex: stall=1, inst_rd_en=0, decode_flush=1. If LOAD_LATENCY > 1, go to LOAD_STALL with cnt = LOAD_LATENCY-1.
  - Else hz_mem: same outputs as hz_ex. If LOAD_LATENCY > 2, go to LOAD_STALL with cnt = LOAD_LATENCY-2.
  - Else: inst_rd_en=1, all other outputs 0.
- LOAD_STALL:
  - Outputs: stall=1, inst_rd_en=0, decode_flush=1. Hazard terms are not re-evaluated.
  - Decrement `cnt` each cycle; when cnt==1, return to RUN next cycle.
  - select_new_pc aborts the stall and is handled exactly as in RUN.
- FLUSH:
  - Outputs: decode_flush=1, inst_rd_en=1, general_flush=0, stall=0.
  - Decrement `cnt`; when cnt==1, return to RUN.
  - A new select_new_pc restarts the flush: general_flush=1 and cnt reloaded.
- Reset (asynchronous, while rst_n=0): state=RUN, cnt=0, counters=0. Outputs are inst_rd_en=0, stall=0, general_flush=1, decode_flush=1, freeze=0.
- The first cycle after reset release behaves as RUN.

## Timing
- Outputs are combinational from the current state plus the current inputs: zero-cycle response on detection. State and `cnt` update on the rising clk edge.
- Load-use hazard in EX costs exactly LOAD_LATENCY bubbles. Hazard in MEM costs LOAD_LATENCY-1.
- A taken branch yields one general_flush cycle followed by FLUSH_CYCLES-1 decode_flush-only cycles.
- dmem_busy cycles extend any stall or flush one-for-one and are never counted as progress.
- Asserting rst_n=0 mid-stall or mid-flush aborts immediately with no residual state.

## Configuration
- HAZARD_CTRL_STATS_EN defined:
  - stall_count increments each cycle stall=1 and freeze=0.
  - flush_count increments each cycle general_flush=1.
  - Both saturate at all-ones.
- HAZARD_CTRL_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package dlx_ctrl_pkg holds:
  - the state enum with encodings RUN=0, LOAD_STALL=1, FLUSH=2;
  - the ADDR_W default;
  - a count-width helper constant.
- One sub-module, hazard_detect: purely combinational, takes the source and destination addresses and enables plus R0_HARDWIRED, and outputs hz_ex and hz_mem.

## Test plan
- LOAD_LATENCY=1: EX load to r3 while decode reads r3 on a -> one cycle with stall=1, inst_rd_en=0, decode_flush=1, then RUN.
- LOAD_LATENCY=2: EX load to r7 with decode b=r7 -> 2 stall cycles. MEM load to r7 -> 1 stall cycle.
- R0_HARDWIRED=1: load to r0 with decode a=r0 -> no stall.
- FLUSH_CYCLES=2: select_new_pc during a LOAD_STALL -> general_flush=1 that cycle, decode_flush only the next cycle, then RUN. Simultaneous hazard is ignored.
- dmem_busy for 3 cycles in the middle of a 3-cycle load stall -> freeze=1 for those 3 cycles, stall resumes with the remaining count, total stall=1 window is 6 cycles.
- Reset asserted mid-FLUSH -> outputs take their reset values immediately. With HAZARD_CTRL_STATS_EN, counters read 0 and saturate when preloaded near all-ones.

Source files
------------

// File: rtl/dlx_ctrl_pkg.sv
// Shared control types for the uDLX decode-stage hazard logic.
// State encoding is fixed so that state values stay stable across builds.
package dlx_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hc_state_e;

  localparam int DLX_ADDR_W = 5;

  // Width of the shared stall/flush down-counter: holds up to 3-1 = 2.
  localparam int HC_CNT_W = 2;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare of the decode sources against the EX and MEM
// destinations, with optional masking of the hardwired-zero register.
module hazard_detect #(
  parameter int ADDR_W       = 5,
  parameter int R0_HARDWIRED = 1
) (
  input  logic              i_ex_load,
  input  logic [ADDR_W-1:0] i_ex_wr_addr,
  input  logic              i_mem_load,
  input  logic [ADDR_W-1:0] i_mem_wr_addr,
  input  logic              i_rd_a_en,
  input  logic [ADDR_W-1:0] i_rd_a_addr,
  input  logic              i_rd_b_en,
  input  logic [ADDR_W-1:0] i_rd_b_addr,
  output logic              o_hz_ex,
  output logic              o_hz_mem
);

  logic w_a_live;
  logic w_b_live;
  logic w_a_ex;
  logic w_b_ex;
  logic w_a_mem;
  logic w_b_mem;

  // A source of r0 can never match a live producer when r0 is hardwired.
  assign w_a_live = i_rd_a_en && !((R0_HARDWIRED != 0) && (i_rd_a_addr == '0));
  assign w_b_live = i_rd_b_en && !((R0_HARDWIRED != 0) && (i_rd_b_addr == '0));

  assign w_a_ex  = w_a_live && (i_rd_a_addr == i_ex_wr_addr);
  assign w_b_ex  = w_b_live && (i_rd_b_addr == i_ex_wr_addr);
  assign w_a_mem = w_a_live && (i_rd_a_addr == i_mem_wr_addr);
  assign w_b_mem = w_b_live && (i_rd_b_addr == i_mem_wr_addr);

  assign o_hz_ex  = i_ex_load  && (w_a_ex  || w_b_ex);
  assign o_hz_mem = i_mem_load && (w_a_mem || w_b_mem);

endmodule

// File: rtl/hazard_control.sv
// Decode-stage hazard and flow-control unit: load-use stalls, branch flushes,
// memory freeze. Define HAZARD_CTRL_STATS_EN to add the stall/flush counters.
module hazard_control
  import dlx_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DLX_ADDR_W,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int R0_HARDWIRED = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_data_rd_en,
  input  logic [ADDR_W-1:0] id_ex_reg_wr_addr,
  input  logic              ex_mem_mem_data_rd_en,
  input  logic [ADDR_W-1:0] ex_mem_reg_wr_addr,
  input  logic              if_id_rd_reg_a_en,
  input  logic              if_id_rd_reg_b_en,
  input  logic [ADDR_W-1:0] if_id_rd_reg_a_addr,
  input  logic [ADDR_W-1:0] if_id_rd_reg_b_addr,
  input  logic              select_new_pc,
  input  logic              dmem_busy,
  output logic              inst_rd_en,
  output logic              stall,
  output logic              general_flush,
  output logic              decode_flush,
  output logic              freeze
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  localparam logic [HC_CNT_W-1:0] CNT_ONE       = HC_CNT_W'(1);
  localparam logic [HC_CNT_W-1:0] FLUSH_RELOAD  = HC_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [HC_CNT_W-1:0] EX_RELOAD     = HC_CNT_W'(LOAD_LATENCY - 1);
  localparam logic [HC_CNT_W-1:0] MEM_RELOAD    = HC_CNT_W'((LOAD_LATENCY > 2) ? (LOAD_LATENCY - 2) : 0);
  localparam hc_state_e           BR_STATE      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam hc_state_e           EX_STATE      = (LOAD_LATENCY > 1) ? LOAD_STALL : RUN;
  localparam hc_state_e           MEM_STATE     = (LOAD_LATENCY > 2) ? LOAD_STALL : RUN;

  hc_state_e             r_state;
  logic [HC_CNT_W-1:0]   r_cnt;

  logic w_hz_ex;
  logic w_hz_mem_raw;
  logic w_hz_mem;
  logic w_cnt_last;
  logic w_inst_rd_en;
  logic w_stall;
  logic w_gflush;
  logic w_dflush;
  logic w_freeze;

  hazard_detect #(
    .ADDR_W       (ADDR_W),
    .R0_HARDWIRED (R0_HARDWIRED)
  ) u_hazard_detect (
    .i_ex_load     (id_ex_mem_data_rd_en),
    .i_ex_wr_addr  (id_ex_reg_wr_addr),
    .i_mem_load    (ex_mem_mem_data_rd_en),
    .i_mem_wr_addr (ex_mem_reg_wr_addr),
    .i_rd_a_en     (if_id_rd_reg_a_en),
    .i_rd_a_addr   (if_id_rd_reg_a_addr),
    .i_rd_b_en     (if_id_rd_reg_b_en),
    .i_rd_b_addr   (if_id_rd_reg_b_addr),
    .o_hz_ex       (w_hz_ex),
    .o_hz_mem      (w_hz_mem_raw)
  );

  // With a single-cycle load the MEM-stage value is already forwardable.
  assign w_hz_mem   = (LOAD_LATENCY >= 2) && w_hz_mem_raw;
  assign w_cnt_last = (r_cnt <= CNT_ONE);

  // State and shared down-counter; a busy data memory holds both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else if (!dmem_busy) begin
      case (r_state)
        FLUSH: begin
          if (select_new_pc) begin
            r_cnt <= FLUSH_RELOAD;
          end else if (w_cnt_last) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        LOAD_STALL: begin
          if (select_new_pc) begin
            r_state <= BR_STATE;
            r_cnt   <= FLUSH_RELOAD;
          end else if (w_cnt_last) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          if (select_new_pc) begin
            r_state <= BR_STATE;
            r_cnt   <= FLUSH_RELOAD;
          end else if (w_hz_ex) begin
            r_state <= EX_STATE;
            r_cnt   <= EX_RELOAD;
          end else if (w_hz_mem) begin
            r_state <= MEM_STATE;
            r_cnt   <= MEM_RELOAD;
          end else begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Outputs react in the same cycle; a redirect looks identical from every state.
  always_comb begin
    w_inst_rd_en = 1'b0;
    w_stall      = 1'b0;
    w_gflush     = 1'b0;
    w_dflush     = 1'b0;
    w_freeze     = 1'b0;
    if (!rst_n) begin
      w_gflush = 1'b1;
      w_dflush = 1'b1;
    end else if (dmem_busy) begin
      w_freeze = 1'b1;
      w_stall  = 1'b1;
    end else if (select_new_pc) begin
      w_inst_rd_en = 1'b1;
      w_gflush     = 1'b1;
      w_dflush     = 1'b1;
    end else if (r_state == FLUSH) begin
      w_inst_rd_en = 1'b1;
      w_dflush     = 1'b1;
    end else if ((r_state == LOAD_STALL) || w_hz_ex || w_hz_mem) begin
      w_stall  = 1'b1;
      w_dflush = 1'b1;
    end else begin
      w_inst_rd_en = 1'b1;
    end
  end

  assign inst_rd_en    = w_inst_rd_en;
  assign stall         = w_stall;
  assign general_flush = w_gflush;
  assign decode_flush  = w_dflush;
  assign freeze        = w_freeze;

`ifdef HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_W'(1));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && !w_freeze) r_stall_count <= sat_inc(r_stall_count);
      if (w_gflush)             r_flush_count <= sat_inc(r_flush_count);
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W != 0);
`endif

endmodule
